mem_access_arbiter: RTL and testbench
=====================================

Name: mem_access_arbiter

Overview:
- Shares the single memory address register and memory port between the instruction-fetch requester and the load/store requester.
- Sequences each access in a fixed order: load address into the MAR, transfer the MAR output, run the memory access, then signal completion.
- Sits between the control unit and the MAR/memory. It drives the MAR's two address inputs and its load (re) and output (we) enables.
- Arbitration between the two requesters is round-robin, with a bus timeout on every access.

Parameters:
- ADDR_W, 15, address width; matches the MAR width.
- TIMEOUT, 15, maximum ACCESS cycles waiting for mem_ready before aborting with an error. Legal range 1 to 2**CNT_W-1.
- CNT_W, 4, width of the timeout counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; held high until if_done.
- if_addr  input  ADDR_W  fetch address; sampled only when the grant is taken.
- if_done  output  1  one-cycle pulse: fetch access finished.
- ls_req  input  1  load/store request; held high until ls_done.
- ls_addr  input  ADDR_W  load/store address; sampled at grant.
- ls_wr  input  1  1 = store, 0 = load; sampled at grant.
- ls_done  output  1  one-cycle pulse: load/store access finished.
- err  output  1  valid only with a done pulse; 1 = access timed out.
- mar_in1  output  ADDR_W  MAR input 1 (fetch path); zero unless the fetch owns the bus.
- mar_in2  output  ADDR_W  MAR input 2 (load/store path); zero unless the load/store owns the bus.
- mar_re  output  1  MAR load enable.
- mar_we  output  1  MAR output-register enable.
- mem_en  output  1  memory access strobe.
- mem_wr  output  1  memory write qualifier; valid while mem_en is high.
- mem_ready  input  1  memory completed the access this cycle.
- busy  output  1  high in every state except IDLE.
- grant_id  output  1  0 = fetch, 1 = load/store; valid while busy.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - All outputs 0; mar_in1 = mar_in2 = 0.
  - Internal owner and address registers 0; timeout counter 0.
  - last_owner = 1, so a fetch wins the first tie.
  - Asserting reset mid-transaction aborts it immediately; no done pulse is issued.
- States: IDLE -> LOAD -> XFER -> ACCESS -> DONE -> IDLE. All outputs are registered or decoded from the state only; there is no combinational path from req to outputs.
- IDLE:
  - Only one request: grant it.
  - Both requests: grant the requester that is not last_owner.
  - On grant: latch owner, the owner's address and (for load/store) ls_wr into internal registers, then go to LOAD.
  - No request: remain in IDLE.
- LOAD (1 cycle):
  - Owner's latched address driven on its MAR input (fetch on mar_in1, load/store on mar_in2); the other input is forced to 0.
  - mar_re = 1.
  - The forced-zero rule guarantees the MAR captures the owner's address, including address 0.
- XFER (1 cycle): mar_we = 1; MAR output updates at the end of this cycle. MAR inputs stay as in LOAD.
- ACCESS:
  - mem_en = 1; mem_wr = latched ls_wr if the owner is load/store, else 0.
  - The counter clears on entry and increments each cycle mem_ready is low.
  - mem_ready high -> DONE with err = 0.
  - Counter == TIMEOUT-1 with mem_ready low -> DONE with err = 1.
  - mem_ready and timeout in the same cycle: mem_ready wins, err = 0.
- DONE (1 cycle):
  - The owner's done output is high for exactly this cycle; err is valid in the same cycle.
  - last_owner = owner; next state IDLE.
- Latency:
  - Request in IDLE at cycle N: LOAD at N+1, XFER at N+2, ACCESS at N+3.
  - With mem_ready at N+3, done is high at N+4.
  - Minimum 5 cycles per access; back-to-back grants possible from N+5.
- Requester obligations:
  - Holding req after done is treated as a new request.
  - Dropping req mid-transaction is ignored; the access completes and done still pulses.
  - Address and ls_wr changes after grant are ignored.
- Fairness: with both requests continuously high, grants strictly alternate. Neither requester waits more than one full transaction.

Test Plan:
- Reset, then if_req=1, if_addr=15'h1234, mem_ready=1 from the first ACCESS cycle -> mar_in1=15'h1234, mar_in2=0 and mar_re=1 at N+1; mar_we=1 at N+2; mem_en=1, mem_wr=0 at N+3; if_done=1, err=0 at N+4.
- ls_req=1, ls_addr=0, ls_wr=1 -> mar_in1=0, mar_in2=0, mar_re=1 in LOAD; mem_wr=1 in ACCESS; ls_done pulse, grant_id=1 throughout.
- if_req and ls_req both held high from reset for 4 transactions -> grant order fetch, load/store, fetch, load/store; each done is a single-cycle pulse.
- mem_ready held 0, TIMEOUT=15 -> ACCESS lasts exactly 15 cycles, then the owner's done=1 with err=1; mem_ready raised on the 15th cycle -> err=0.
- rst_n dropped during ACCESS -> all outputs 0 immediately, no done pulse; after release, a pending if_req restarts at LOAD.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// Memory access arbiter: shares one MAR and memory port between the
// instruction-fetch and load/store requesters. Each access walks
// IDLE -> LOAD -> XFER -> ACCESS -> DONE. Requesters are served
// round-robin, and every ACCESS is bounded by a timeout.
// All outputs are decoded from registered state only, so there is no
// combinational path from a request input to any output.
module mem_access_arbiter #(
    parameter int ADDR_W  = 15,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    input  logic              ls_req,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              ls_wr,
    output logic              ls_done,
    output logic              err,
    output logic [ADDR_W-1:0] mar_in1,
    output logic [ADDR_W-1:0] mar_in2,
    output logic              mar_re,
    output logic              mar_we,
    output logic              mem_en,
    output logic              mem_wr,
    input  logic              mem_ready,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        XFER   = 3'd2,
        ACCESS = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Owner encoding: 0 = fetch, 1 = load/store.
    localparam logic              OWN_IF   = 1'b0;
    localparam logic              OWN_LS   = 1'b1;
    // Last counter value before the access is abandoned.
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic                wr_q,    wr_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                last_q,  last_d;
    logic                err_q,   err_d;
    logic                gnt;

    // State and transaction context registers; last_owner resets to
    // load/store so a fetch wins the very first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            last_q  <= OWN_LS;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: arbitration in IDLE, fixed sequencing after that,
    // and the timeout counter in ACCESS.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        err_d   = err_q;
        gnt     = OWN_IF;
        case (state_q)
            IDLE: begin
                if (if_req || ls_req) begin
                    // On a tie, serve whoever did not own the bus last.
                    if (if_req && ls_req) gnt = ~last_q;
                    else                  gnt = ls_req;
                    owner_d = gnt;
                    addr_d  = (gnt == OWN_LS) ? ls_addr : if_addr;
                    wr_d    = (gnt == OWN_LS) ? ls_wr : 1'b0;
                    err_d   = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = XFER;
            XFER: begin
                // Counter starts clean for every access.
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                // A ready memory wins over a coincident timeout.
                if (mem_ready) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from registered state. The non-owner MAR input is held
    // at zero so the MAR captures exactly the owner's address, even 0.
    assign busy     = (state_q != IDLE);
    assign grant_id = busy & owner_q;
    assign mar_in1  = (busy && owner_q == OWN_IF) ? addr_q : '0;
    assign mar_in2  = (busy && owner_q == OWN_LS) ? addr_q : '0;
    assign mar_re   = (state_q == LOAD);
    assign mar_we   = (state_q == XFER);
    assign mem_en   = (state_q == ACCESS);
    assign mem_wr   = (state_q == ACCESS) & (owner_q == OWN_LS) & wr_q;
    assign if_done  = (state_q == DONE) & (owner_q == OWN_IF);
    assign ls_done  = (state_q == DONE) & (owner_q == OWN_LS);
    assign err      = (state_q == DONE) & err_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a transaction scoreboard:
// each expected access is queued when stimulus is applied and checked as
// the DUT walks through LOAD, ACCESS and DONE.
module tb_mem_access_arbiter;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, ls_req, ls_wr, mem_ready;
    logic [AW-1:0] if_addr, ls_addr;
    logic          if_done, ls_done, err, mar_re, mar_we, mem_en, mem_wr;
    logic          busy, grant_id;
    logic [AW-1:0] mar_in1, mar_in2;

    typedef struct {
        logic          id;
        logic [AW-1:0] addr;
        logic          wr;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    mem_access_arbiter #(.ADDR_W(AW), .TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
        .ls_req(ls_req), .ls_addr(ls_addr), .ls_wr(ls_wr), .ls_done(ls_done),
        .err(err), .mar_in1(mar_in1), .mar_in2(mar_in2),
        .mar_re(mar_re), .mar_we(mar_we), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_ready(mem_ready), .busy(busy), .grant_id(grant_id)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [40:0] all_outs();
        return {if_done, ls_done, err, mar_in1, mar_in2, mar_re, mar_we,
                mem_en, mem_wr, busy, grant_id};
    endfunction

    // Scoreboard monitor: LOAD address routing, ACCESS write qualifier,
    // done owner/err, and single-cycle done pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_done) chk("done_pulse_width", {if_done, ls_done}, 2'b00);
            if (mar_re) begin
                if (sb.size() == 0) chk("sb_load_unexpected", 1, 0);
                else begin
                    chk("sb_load_gid", grant_id, sb[0].id);
                    chk("sb_load_in1", mar_in1, sb[0].id ? '0 : sb[0].addr);
                    chk("sb_load_in2", mar_in2, sb[0].id ? sb[0].addr : '0);
                end
            end
            if (mem_en && sb.size() != 0) chk("sb_acc_wr", mem_wr, sb[0].wr);
            if (if_done || ls_done) begin
                if (sb.size() == 0) chk("sb_done_unexpected", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_done_who", {ls_done, if_done}, e.id ? 2'b10 : 2'b01);
                    chk("sb_done_err", err, e.err);
                end
            end
            prev_done <= if_done | ls_done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    initial begin
        int n;
        logic got;
        logic [3:0] order;
        int k;

        rst_n = 1'b0; if_req = 0; ls_req = 0; ls_wr = 0; mem_ready = 0;
        if_addr = '0; ls_addr = '0;
        repeat (2) @(negedge clk);
        chk("reset_outs", all_outs(), '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // Single fetch, memory ready immediately.
        if_req = 1; if_addr = 15'h1234; mem_ready = 1;
        sb.push_back('{1'b0, 15'h1234, 1'b0, 1'b0});
        @(negedge clk);
        chk("t1_load", {mar_re, mar_in1, mar_in2}, {1'b1, 15'h1234, 15'h0});
        chk("t1_busy_gid", {busy, grant_id}, 2'b10);
        @(negedge clk);
        chk("t1_xfer", {mar_re, mar_we}, 2'b01);
        @(negedge clk);
        chk("t1_access", {mem_en, mem_wr}, 2'b10);
        @(negedge clk);
        chk("t1_done", {if_done, ls_done, err}, 3'b100);
        if_req = 0;
        @(negedge clk);
        chk("t1_idle", {busy, if_done}, 2'b00);

        // Store to address 0.
        ls_req = 1; ls_addr = 15'h0; ls_wr = 1;
        sb.push_back('{1'b1, 15'h0, 1'b1, 1'b0});
        @(negedge clk);
        chk("t2_load", {mar_re, mar_in1, mar_in2, grant_id}, {1'b1, 15'h0, 15'h0, 1'b1});
        @(negedge clk);
        chk("t2_xfer_gid", {mar_we, grant_id}, 2'b11);
        @(negedge clk);
        chk("t2_access", {mem_en, mem_wr, grant_id}, 3'b111);
        @(negedge clk);
        chk("t2_done", {ls_done, if_done, err, grant_id}, 4'b1001);
        ls_req = 0; ls_wr = 0;
        @(negedge clk);
        chk("t2_idle", busy, 1'b0);

        // Both requesting continuously: strict alternation, fetch first.
        if_req = 1; if_addr = 15'h0aaa; ls_req = 1; ls_addr = 15'h5555; ls_wr = 0;
        sb.push_back('{1'b0, 15'h0aaa, 1'b0, 1'b0});
        sb.push_back('{1'b1, 15'h5555, 1'b0, 1'b0});
        sb.push_back('{1'b0, 15'h0aaa, 1'b0, 1'b0});
        sb.push_back('{1'b1, 15'h5555, 1'b0, 1'b0});
        k = 0; order = '0;
        for (int i = 0; i < 60 && k < 4; i++) begin
            @(negedge clk);
            if (if_done || ls_done) begin
                order[k] = ls_done;
                k++;
                if (k == 4) begin if_req = 0; ls_req = 0; end
            end
        end
        chk("t3_count", k, 4);
        chk("t3_order", order, 4'b1010);
        @(negedge clk);
        chk("t3_idle", busy, 1'b0);

        // Timeout: memory never ready.
        if_req = 1; if_addr = 15'h0777; mem_ready = 0;
        sb.push_back('{1'b0, 15'h0777, 1'b0, 1'b1});
        n = 0; got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (mem_en) n++;
            if (if_done || ls_done) begin
                got = 1;
                chk("t4_err", {if_done, err}, 2'b11);
                if_req = 0;
            end
        end
        chk("t4_seen_done", got, 1'b1);
        chk("t4_access_len", n, 15);
        @(negedge clk);

        // Ready arrives on the last allowed cycle: ready wins.
        ls_req = 1; ls_addr = 15'h2abc; ls_wr = 0; mem_ready = 0;
        sb.push_back('{1'b1, 15'h2abc, 1'b0, 1'b0});
        n = 0; got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (mem_en) begin
                n++;
                if (n == 15) mem_ready = 1;
            end
            if (if_done || ls_done) begin
                got = 1;
                chk("t4b_err", {ls_done, err}, 2'b10);
                ls_req = 0; mem_ready = 0;
            end
        end
        chk("t4b_seen_done", got, 1'b1);
        chk("t4b_access_len", n, 15);
        @(negedge clk);

        // Reset mid-ACCESS aborts silently; pending fetch restarts after.
        if_req = 1; if_addr = 15'h0042; mem_ready = 0;
        sb.push_back('{1'b0, 15'h0042, 1'b0, 1'b0});
        repeat (3) @(negedge clk);
        chk("t5_in_access", mem_en, 1'b1);
        #1 rst_n = 1'b0;
        sb.delete();
        #1 chk("t5_reset_outs", all_outs(), '0);
        @(posedge clk);
        @(negedge clk);
        chk("t5_no_done", all_outs(), '0);
        mem_ready = 1;
        rst_n = 1'b1;
        sb.push_back('{1'b0, 15'h0042, 1'b0, 1'b0});
        @(negedge clk);
        chk("t5_restart_load", {mar_re, mar_in1}, {1'b1, 15'h0042});
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (if_done || ls_done) begin got = 1; if_req = 0; end
        end
        chk("t5_seen_done", got, 1'b1);
        @(negedge clk);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
